dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Shares the single-port data DRAM between the pipeline's MEM stage (CPU port) and a secondary DMA/trace requester. Arbitrates per transaction with CPU priority and a starvation bound for DMA. Sequences each access through a small FSM that absorbs a parameterised DRAM read latency. Drives `cpu_stall` so the pipeline freezes until its own access completes.

## Interface
- `ADDR_W`, 32: byte-address width of both requester ports.
- `DATA_W`, 32: data width.
- `READ_LAT`, 0: cycles from `dram_addr` being presented until `dram_rdata` is valid. Range 0..3; 0 means a combinational-read DRAM.
- `STARVE_MAX`, 4: maximum consecutive CPU grants while `dma_req` is pending. Range 1..15.
- `cpu_clk` in 1: the single clock; everything is on its rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request. Held high with stable operands until `cpu_ack`.
- `cpu_we` in 1: 1 means write, 0 means read.
- `cpu_addr` in ADDR_W: byte address. Bits [1:0] are ignored.
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data. Valid in the `cpu_ack` cycle and held until the next CPU read completes.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: pipeline freeze. Equals `cpu_req & ~cpu_ack` and is combinational.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same as the CPU port.
- `dram_addr` out ADDR_W-2: word address, equal to the granted `addr[ADDR_W-1:2]`.
- `dram_wdata` out DATA_W: write data to DRAM.
- `dram_we` out 1: DRAM write enable.
- `dram_rdata` in DATA_W: DRAM read data.

## Operation
- FSM states are IDLE, ACCESS, WAIT and DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and register its `we`/`addr`/`wdata` into `dram_*`.
  - Record the owner (CPU or DMA) and go to ACCESS.
- **Arbitration (IDLE only)**
  - CPU only requesting: CPU wins.
  - DMA only requesting: DMA wins.
  - Both requesting: CPU wins unless `starve_cnt == STARVE_MAX`, in which case DMA wins.
- **`starve_cnt` update**
  - Increments (saturating) on a CPU grant while `dma_req` is high.
  - Clears on a DMA grant.
  - Clears on a CPU grant while `dma_req` is low.
- **ACCESS**
  - `dram_we` is high for exactly this cycle if the transaction is a write.
  - Write: go to DONE.
  - Read with `READ_LAT=0`: capture `dram_rdata` into the owner's rdata register, then go to DONE.
  - Read with `READ_LAT>0`: load `lat_cnt = READ_LAT-1` and go to WAIT.
- **WAIT**
  - `dram_addr` is held and `dram_we` is 0.
  - When `lat_cnt == 0`: capture `dram_rdata` into the owner's rdata and go to DONE.
  - Otherwise decrement `lat_cnt`.
- **DONE**
  - The owner's ack is high (registered). The other port's ack stays 0.
  - Always return to IDLE.
- Requesters see the ack at the DONE edge and either drop `req` or present a new transaction.
  - DONE always returns to IDLE, so a stale `req` level is never re-granted.
- The non-owner's rdata register is never modified.
- `dram_addr` and `dram_wdata` hold their last values in IDLE; only `dram_we` is forced to 0.
- Operand changes by a requester while it is not yet granted are legal.
- Operand changes after grant are ignored, because operands are latched.

## Timing
- Reset (synchronous, at the next edge with `cpu_rst=1`):
  - State goes to IDLE.
  - `starve_cnt` and `lat_cnt` are set to 0.
  - `dram_addr`, `dram_wdata`, `dram_we`, `cpu_rdata`, `dma_rdata`, `cpu_ack` and `dma_ack` are all set to 0.
- `cpu_stall` is combinational, so it follows `cpu_req` even during reset.
- Reset mid-transaction: the transaction is abandoned with no ack, and the requester must reissue it.
  - A write whose ACCESS cycle coincides with the reset edge is committed by the DRAM but not acknowledged.
- Latency is counted from the request sampled in IDLE at cycle 0:
  - Write: ACCESS at c1, ack at c2.
  - Read: ack at c(2+READ_LAT).
- Throughput: one transaction every 3+READ_LAT cycles (including the IDLE cycle).
- `cpu_stall` stays high from the first cycle of `cpu_req` through the cycle before `cpu_ack`. It is low in the ack cycle so the pipeline advances on that edge.
- A request arriving in ACCESS, WAIT or DONE waits for the next IDLE.
- Simultaneous `cpu_req` and `dma_req` rising in the same IDLE cycle are resolved purely by the arbitration rule above.

## Test plan
- **CPU read, `READ_LAT=0`:** mem[0x10>>2]=0xDEADBEEF; cpu_req=1, we=0, addr=0x10 at c0 -> `dram_addr`=4 at c1; `cpu_ack`=1 and `cpu_rdata`=0xDEADBEEF at c2; `cpu_stall`=1 at c0–c1, 0 at c2.
- **CPU write then read, `READ_LAT=2`:** write 0x12345678 to 0x20 -> `dram_we`=1 only at c1, ack at c2; read back -> ack 4 cycles after IDLE sample, `cpu_rdata`=0x12345678.
- **Contention, `STARVE_MAX=4`:** `cpu_req` and `dma_req` held continuously -> grant order CPU, CPU, CPU, CPU, DMA, CPU…; `dma_ack` is never more than 5 transactions apart.
- **Isolation:** DMA reads 0xAAAA5555 while `cpu_rdata`=0x11111111 -> `cpu_rdata` unchanged, `cpu_ack` stays 0, `cpu_stall`=0 when `cpu_req`=0.
- **Reset mid-read (`READ_LAT=3`):** assert `cpu_rst` in WAIT -> next cycle all outputs 0, no ack; reissued read completes normally with correct data.
- **Back-to-back:** CPU presents a new address in the ack cycle -> a second grant in the following IDLE with no duplicate ack for the first address.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: CPU/DMA arbiter for a single-port data DRAM with a read-latency sequencing FSM
module dram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-3:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  input  logic [DATA_W-1:0] dram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  state_t state;
  logic owner, grant_dma, finish;
  logic [3:0] starve_cnt;
  logic [1:0] lat_cnt;
  logic unused_addr_bits;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};
  // dram_we is only high in ACCESS, so it doubles as the latched write flag there
  always_comb begin
    grant_dma = dma_req & (~cpu_req | (starve_cnt == 4'(STARVE_MAX)));
    finish = state == ACCESS ? (dram_we | (READ_LAT == 0)) : (state == WAIT) && (lat_cnt == '0);
  end
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= IDLE;
      owner <= 1'b0;
      starve_cnt <= '0;
      lat_cnt <= '0;
      dram_addr <= '0;
      dram_wdata <= '0;
      dram_we <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
    end else begin
      dram_we <= 1'b0;
      cpu_ack <= finish & ~owner;
      dma_ack <= finish & owner;
      if (finish & ~dram_we & ~owner) cpu_rdata <= dram_rdata;
      if (finish & ~dram_we & owner) dma_rdata <= dram_rdata;
      case (state)
        IDLE: if (cpu_req | dma_req) begin
          owner <= grant_dma;
          dram_we <= grant_dma ? dma_we : cpu_we;
          dram_addr <= grant_dma ? dma_addr[ADDR_W-1:2] : cpu_addr[ADDR_W-1:2];
          dram_wdata <= grant_dma ? dma_wdata : cpu_wdata;
          starve_cnt <= (grant_dma | ~dma_req) ? '0 : starve_cnt + {3'b0, starve_cnt != 4'hf};
          state <= ACCESS;
        end
        ACCESS: if (finish) state <= DONE;
        else begin
          lat_cnt <= 2'(READ_LAT > 0 ? READ_LAT - 1 : 0);
          state <= WAIT;
        end
        WAIT: if (finish) state <= DONE;
        else lat_cnt <= lat_cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed vectors, corner sequences and a randomized transaction-level model
module tb_dram_arbiter;
  localparam int LAT = 2;
  localparam int SM = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, dram_wdata, dram_rdata;
  logic [29:0] dram_addr;
  logic cpu_ack, cpu_stall, dma_ack, dram_we;
  int total = 0, bad = 0;
  logic [31:0] exp_c = '0, exp_d = '0;
  logic [31:0] mem [64];
  logic [31:0] mref [64];
  logic [5:0] rp0 = '0, rp1 = '0;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(LAT), .STARVE_MAX(SM)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_rdata(dram_rdata)
  );

  // DRAM with a LAT=2 read pipeline on the presented address
  always @(posedge clk) begin
    if (dram_we) mem[dram_addr[5:0]] <= dram_wdata;
    rp0 <= dram_addr[5:0];
    rp1 <= rp0;
  end
  assign dram_rdata = mem[rp1];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic reset_dut;
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_c = '0;
    exp_d = '0;
  endtask

  task automatic txn(input logic d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input int elat);
    @(negedge clk);
    if (d) begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    #1 chk("stall_on_req", cpu_stall, !d);
    for (int k = 1; k <= elat; k++) begin
      @(negedge clk);
      chk("own_ack", d ? dma_ack : cpu_ack, k == elat);
      chk("other_ack", d ? cpu_ack : dma_ack, 0);
      chk("stall", cpu_stall, !d && k < elat);
      if (k == elat && !we) begin
        if (d) exp_d = erd;
        else exp_c = erd;
      end
    end
    chk("cpu_rdata", cpu_rdata, exp_c);
    chk("dma_rdata", dma_rdata, exp_d);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    chk("dup_ack", cpu_ack | dma_ack, 0);
  endtask

  task automatic new_op(output logic we, output logic [31:0] a, output logic [31:0] wd);
    we = 1'($urandom_range(0, 1));
    a = 32'($urandom_range(0, 255));
    wd = $urandom;
  endtask

  typedef struct {
    logic d;
    logic we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    int lat;
  } vec_t;
  vec_t v [9];

  int cyc, free_at, ec, ed, starve, n;
  logic c_rd, d_rd, gd, we_g;
  logic [31:0] pc, pd, wd_g;
  logic [5:0] a_g;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h01010101;
    mem[4] <= 32'hDEADBEEF;
    v[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2 + LAT};
    v[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 2};
    v[2] = '{1'b0, 1'b0, 32'h23, 32'h0, 32'h12345678, 2 + LAT};
    v[3] = '{1'b0, 1'b1, 32'h30, 32'h11111111, 32'h0, 2};
    v[4] = '{1'b0, 1'b0, 32'h30, 32'h0, 32'h11111111, 2 + LAT};
    v[5] = '{1'b1, 1'b1, 32'h40, 32'hAAAA5555, 32'h0, 2};
    v[6] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'hAAAA5555, 2 + LAT};
    v[7] = '{1'b1, 1'b1, 32'h10, 32'h0BADF00D, 32'h0, 2};
    v[8] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 2 + LAT};
    // reset values; stall follows cpu_req even while in reset
    rst = 1'b1;
    cpu_req = 1'b1;
    @(negedge clk);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_outs", {cpu_ack, dma_ack, dram_we}, 0);
    chk("rst_addr", {2'b0, dram_addr}, 0);
    chk("rst_wdata", dram_wdata, 0);
    chk("rst_crd", cpu_rdata, 0);
    chk("rst_drd", dma_rdata, 0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) txn(v[i].d, v[i].we, v[i].a, v[i].wd, v[i].erd, v[i].lat);
    // back-to-back: new address presented in the ack cycle
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    for (int k = 1; k <= 2 + LAT; k++) @(negedge clk);
    chk("b2b_ack1", cpu_ack, 1);
    chk("b2b_rd1", cpu_rdata, 32'h12345678);
    cpu_addr = 32'h30;
    for (int k = 1; k <= 3 + LAT; k++) begin
      @(negedge clk);
      chk("b2b_ack2", cpu_ack, k == 3 + LAT);
    end
    chk("b2b_rd2", cpu_rdata, 32'h11111111);
    cpu_req = 1'b0;
    @(negedge clk);
    // reset while the read sits in WAIT
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_acks", {cpu_ack, dma_ack, dram_we}, 0);
    chk("mid_rst_addr", {2'b0, dram_addr}, 0);
    chk("mid_rst_wdata", dram_wdata, 0);
    chk("mid_rst_crd", cpu_rdata, 0);
    chk("mid_rst_drd", dma_rdata, 0);
    rst = 1'b0;
    exp_c = '0;
    exp_d = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("mid_rst_noack", cpu_ack, 0);
    end
    txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h12345678, 2 + LAT);
    // contention: both held high, every fifth grant goes to DMA
    reset_dut;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    n = 0;
    for (int t = 0; t < 100 && n < 10; t++) begin
      @(negedge clk);
      if (cpu_ack | dma_ack) begin
        chk("both_ack", {31'b0, cpu_ack & dma_ack}, 0);
        chk("grant_order", {31'b0, dma_ack}, {31'b0, n % 5 == 4});
        n++;
      end
    end
    chk("grant_count", n, 10);
    // randomized traffic against a transaction-level model
    reset_dut;
    for (int i = 0; i < 64; i++) mref[i] = mem[i];
    cyc = 0; free_at = 0; ec = -1; ed = -1; starve = 0;
    c_rd = 1'b0; d_rd = 1'b0; pc = '0; pd = '0;
    repeat (3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == ec && c_rd) exp_c = pc;
      if (cyc == ed && d_rd) exp_d = pd;
      chk("r_cpu_ack", {31'b0, cpu_ack}, {31'b0, cyc == ec});
      chk("r_dma_ack", {31'b0, dma_ack}, {31'b0, cyc == ed});
      chk("r_cpu_rdata", cpu_rdata, exp_c);
      chk("r_dma_rdata", dma_rdata, exp_d);
      chk("r_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && cyc != ec});
      if (cpu_req && cyc == ec) begin
        cpu_req = 1'($urandom_range(0, 1));
        if (cpu_req) new_op(cpu_we, cpu_addr, cpu_wdata);
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1;
        new_op(cpu_we, cpu_addr, cpu_wdata);
      end
      if (dma_req && cyc == ed) begin
        dma_req = 1'($urandom_range(0, 1));
        if (dma_req) new_op(dma_we, dma_addr, dma_wdata);
      end else if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1'b1;
        new_op(dma_we, dma_addr, dma_wdata);
      end
      if (cyc >= free_at && (cpu_req || dma_req)) begin
        gd = dma_req && (!cpu_req || starve == SM);
        starve = (gd || !dma_req) ? 0 : (starve < 15 ? starve + 1 : 15);
        we_g = gd ? dma_we : cpu_we;
        a_g = gd ? dma_addr[7:2] : cpu_addr[7:2];
        wd_g = gd ? dma_wdata : cpu_wdata;
        free_at = cyc + (we_g ? 2 : 2 + LAT) + 1;
        if (gd) begin
          ed = free_at - 1; d_rd = !we_g; pd = mref[a_g];
        end else begin
          ec = free_at - 1; c_rd = !we_g; pc = mref[a_g];
        end
        if (we_g) mref[a_g] = wd_g;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
